lfsr_seq_ctrl: RTL
==================

Name: lfsr_seq_ctrl

Overview:
Sequencer and arbiter that shares one loadable LFSR counter (DW03_lfsr_load) between NREQ requesters. A granted requester supplies a seed and a step count. The block loads the seed, enables the counter for exactly that many steps, captures the resulting count, and returns it with a done pulse. It sits between the client logic and the LFSR instance and drives that instance's load_n/cen/data; the LFSR keeps its own reset.

Parameters:
WIDTH, 4, LFSR/counter width in bits; must match the LFSR instance.
CNT_W, 8, width of each step-count field; max run 2**CNT_W-1 steps.
NREQ, 2, number of requesters (>=2).

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
req  input  NREQ  per-requester request, level
seed_in  input  NREQ*WIDTH  per-requester seed, slice i = [i*WIDTH +: WIDTH]
steps_in  input  NREQ*CNT_W  per-requester step count, slice i = [i*CNT_W +: CNT_W]
ack  output  NREQ  one-cycle grant pulse, one-hot
done  output  NREQ  one-cycle completion pulse, one-hot
rsp_data  output  WIDTH  captured count, valid with done
busy  output  1  high when state != IDLE
lfsr_data  output  WIDTH  to LFSR data
lfsr_load_n  output  1  to LFSR load_n, active low
lfsr_cen  output  1  to LFSR cen
lfsr_count  input  WIDTH  from LFSR count

Behaviour:
- Fixed LFSR contract: load_n=0 at an edge loads data into count; cen=1 at an edge advances one step; load has priority over cen.
- Reset values (sync rst=1): state=IDLE, ack=0, done=0, rsp_data=0, busy=0, lfsr_load_n=1, lfsr_cen=0, lfsr_data=0, rr pointer=0, owner/seed/remaining regs=0.
- States: IDLE, LOAD, RUN, CAPTURE. The state is registered. lfsr_load_n, lfsr_cen, lfsr_data and busy are decoded from state and latched registers only, never from raw req.
- IDLE: if any req, grant requester i chosen round-robin starting at rr pointer. Latch owner=i, seed=seed_in[i], remaining=steps_in[i], then go to LOAD. If no req, stay.
- LOAD (1 cycle): ack[owner]=1, lfsr_load_n=0, lfsr_data=seed. Next state is RUN if remaining!=0, else CAPTURE.
- RUN: lfsr_cen=1, remaining decrements each cycle. When remaining==1, next state is CAPTURE. Exactly steps_in cen-cycles are issued.
- CAPTURE (1 cycle): rsp_data<=lfsr_count at the edge; done[owner]<=1 for the following cycle; rr pointer<=(owner+1) mod NREQ; next state IDLE.
- Timing: with req sampled in IDLE at cycle 0, LOAD is cycle 1 and RUN is cycles 2..N+1. CAPTURE is cycle N+2 and done/rsp_data appear at cycle N+3. The block is back in IDLE at N+3 and may grant again that cycle. Back-to-back transactions therefore take N+3 cycles each.
- rsp_data holds its value until the next CAPTURE.
- Requester rules: hold seed/steps stable while req=1 until ack. May drop req after ack; req during a run is ignored until IDLE. Holding req after done re-requests.
- Simultaneous req: round-robin only, no starvation. With NREQ=2 and both held, grants alternate 0,1,0,1 from reset.
- Synchronous rst mid-operation: next cycle is IDLE with reset values; no done is emitted for the aborted run. LFSR contents are left as-is.
- steps_in=0: load then capture; rsp_data=seed.

Optional Feature:
LFSR_SEQ_ABORT_EN.
- Defined: adds input abort (NREQ bits) and output rsp_err (1 bit, reset 0). If abort[owner]=1 in LOAD or RUN, lfsr_cen=0 that cycle and the next state is IDLE. done[owner]=1 and rsp_err=1 the next cycle, rsp_data unchanged, rr pointer advances. Otherwise rsp_err=0 with done.
- Undefined: no abort/rsp_err ports; every granted run completes.

Test Plan:
- Reset then req[0], seed 4'hA, steps 0 -> ack[0] at cycle 1, done[0] at cycle 3, rsp_data=4'hA, zero cen cycles.
- req[1], seed 4'h3, steps 5 -> exactly 5 cycles of lfsr_cen=1 after a single load_n=0 cycle; done[1] at cycle 8; rsp_data equals the bench LFSR model after 5 steps from 4'h3.
- req[0] and req[1] held together, steps 2 each -> grants 0,1,0,1; done pulses spaced 5 cycles apart; ack/done always one-hot.
- rst=1 during RUN of a steps=10 job -> IDLE and busy=0 next cycle, no done, load_n=1, cen=0; new req after reset is served normally.
- steps 8'hFF, seed 4'h1 -> 255 cen cycles, done at cycle 258, no counter wrap or early exit.
- With LFSR_SEQ_ABORT_EN: abort[0] at the 3rd RUN cycle of a steps=10 job -> cen drops that cycle, done[0]=1 with rsp_err=1 next cycle, rsp_data unchanged.

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl
// Shares one loadable LFSR counter between NREQ requesters. A granted
// requester supplies a seed and a step count. The block loads the seed,
// clocks the counter for exactly that many steps, captures the resulting
// count and returns it together with a one-cycle done pulse.
//
// Optional feature macro: LFSR_SEQ_ABORT_EN
//   When defined, adds the abort input and rsp_err output so that the
//   owner can cut a run short.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req          per-requester level request
//   seed_in      per-requester seed, slice i = [i*WIDTH +: WIDTH]
//   steps_in     per-requester step count, slice i = [i*CNT_W +: CNT_W]
//   ack          one-cycle one-hot grant pulse (during LOAD)
//   done         one-cycle one-hot completion pulse
//   rsp_data     captured count, valid with done, held until next capture
//   busy         high whenever the sequencer is not idle
//   lfsr_data    seed to the LFSR data input
//   lfsr_load_n  LFSR load strobe, active low
//   lfsr_cen     LFSR count enable
//   lfsr_count   current LFSR count
//   abort        (optional) per-requester abort of the running job
//   rsp_err      (optional) high with done when the job was aborted
module lfsr_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] seed_in,
    input  logic [NREQ*CNT_W-1:0] steps_in,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy,
    output logic [WIDTH-1:0]      lfsr_data,
    output logic                  lfsr_load_n,
    output logic                  lfsr_cen,
`ifdef LFSR_SEQ_ABORT_EN
    input  logic [NREQ-1:0]       abort,
    output logic                  rsp_err,
`endif
    input  logic [WIDTH-1:0]      lfsr_count
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [OW-1:0]     owner;
    logic [OW-1:0]     rr_ptr;
    logic [OW-1:0]     next_owner;
    logic [OW-1:0]     grant_idx;
    logic              grant_vld;
    logic [WIDTH-1:0]  seed_r;
    logic [CNT_W-1:0]  remaining;
    logic              abort_hit;
    int                cand;

    // Round-robin pick: scan requesters starting at rr_ptr and take the
    // first one that is requesting.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = OW'(cand);
            end
        end
    end

    // Pointer value used after a job finishes so the owner goes to the
    // back of the queue.
    assign next_owner = OW'((int'(owner) + 1) % NREQ);

`ifdef LFSR_SEQ_ABORT_EN
    assign abort_hit = abort[owner] && ((state == LOAD) || (state == RUN));
`else
    assign abort_hit = 1'b0;
`endif

    // Next-state logic. LOAD with a zero step count goes straight to
    // CAPTURE so the captured value is the seed itself.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = LOAD;
            LOAD:    begin
                if (abort_hit)             state_nxt = IDLE;
                else if (remaining != '0)  state_nxt = RUN;
                else                       state_nxt = CAPTURE;
            end
            RUN:     begin
                if (abort_hit)                 state_nxt = IDLE;
                else if (remaining == CNT_W'(1)) state_nxt = CAPTURE;
                else                           state_nxt = RUN;
            end
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // LFSR controls and status are decoded from state and latched job
    // registers only, so client request wiggles cannot reach the counter.
    always_comb begin
        ack         = '0;
        lfsr_load_n = 1'b1;
        lfsr_cen    = 1'b0;
        lfsr_data   = seed_r;
        busy        = (state != IDLE);
        if (state == LOAD) begin
            ack         = NREQ'(1) << owner;
            lfsr_load_n = 1'b0;
        end
        if ((state == RUN) && !abort_hit) begin
            lfsr_cen = 1'b1;
        end
    end

    // State and job registers. done is a registered pulse so it lands in
    // the cycle after CAPTURE (or after an abort).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            seed_r    <= '0;
            remaining <= '0;
            done      <= '0;
            rsp_data  <= '0;
`ifdef LFSR_SEQ_ABORT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= '0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner     <= grant_idx;
                        seed_r    <= seed_in[int'(grant_idx)*WIDTH +: WIDTH];
                        remaining <= steps_in[int'(grant_idx)*CNT_W +: CNT_W];
                    end
                end
                RUN: begin
                    remaining <= remaining - CNT_W'(1);
                end
                CAPTURE: begin
                    rsp_data <= lfsr_count;
                    done     <= NREQ'(1) << owner;
                    rr_ptr   <= next_owner;
`ifdef LFSR_SEQ_ABORT_EN
                    rsp_err  <= 1'b0;
`endif
                end
                default: ;
            endcase
            if (abort_hit) begin
                done   <= NREQ'(1) << owner;
                rr_ptr <= next_owner;
`ifdef LFSR_SEQ_ABORT_EN
                rsp_err <= 1'b1;
`endif
            end
        end
    end

endmodule
